// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
//  Module   : alu_top
//  Purpose  : Registered WIDTH-bit ALU driving the board LEDs. Operands and
//             opcode are sampled on every rising clock edge. The result and
//             the zero and carry flags are registered and held until the
//             next edge. There is no handshake, and a new result appears
//             every cycle.
//  Ports    : clk     - system clock, all state on rising edge
//             rst_n   - synchronous active-low reset
//             A, B    - WIDTH-bit unsigned operands
//             opcode  - 3-bit operation select
//                       (ADD SUB AND OR XOR NOT SHL SHR)
//             led     - registered WIDTH-bit result
//             z       - registered zero flag (result all zero)
//             c       - registered carry / borrow / shift-out flag
//  Revision : 1.0  initial release
// ============================================================================
module alu_top #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] led,
    output logic             z,
    output logic             c
);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_not = 3'b101;
    localparam logic [2:0] c_op_shl = 3'b110;
    localparam logic [2:0] c_op_shr = 3'b111;

    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic             w_z;
    logic [WIDTH:0]   w_sum;

    logic [WIDTH-1:0] r_led;
    logic             r_z;
    logic             r_c;

    // The operands come straight from switches and buttons. They are
    // captured directly, without a synchroniser, so that the result still
    // appears one edge later. The output register is the only state.
    // A one-bit-wider add exposes the carry out of the MSB.
    assign w_sum = {1'b0, A} + {1'b0, B};

    always_comb begin
        w_y = '0;
        w_c = 1'b0;
        case (opcode)
            c_op_add: begin
                w_y = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
            end
            c_op_sub: begin
                w_y = A - B;
                w_c = (A < B);   // borrow
            end
            c_op_and: w_y = A & B;
            c_op_or:  w_y = A | B;
            c_op_xor: w_y = A ^ B;
            c_op_not: w_y = ~A;
            c_op_shl: begin
                w_y = {A[WIDTH-2:0], 1'b0};
                w_c = A[WIDTH-1];
            end
            c_op_shr: begin
                w_y = {1'b0, A[WIDTH-1:1]};
                w_c = A[0];
            end
            default: begin
                w_y = '0;
                w_c = 1'b0;
            end
        endcase
    end

    // The zero flag looks only at the result bits and never at the carry.
    assign w_z = (w_y == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
        end else begin
            r_led <= w_y;
            r_z   <= w_z;
            r_c   <= w_c;
        end
    end

    assign led = r_led;
    assign z   = r_z;
    assign c   = r_c;

endmodule
`default_nettype wire

// File: tb/tb_alu_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_top
//  Purpose  : Scoreboard testbench for alu_top. The stimulus process drives
//             one directed vector per cycle and pushes the hand-computed
//             {led,z,c} into a queue. The monitor process pops one entry
//             and compares it one edge after each vector is captured.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_top;

    localparam int c_width = 4;

    logic               clk;
    logic               rst_n;
    logic [c_width-1:0] a;
    logic [c_width-1:0] b;
    logic [2:0]         opcode;
    logic [c_width-1:0] led;
    logic               z;
    logic               c;

    logic [c_width+1:0] exp_q[$];    // {led, z, c}
    string              name_q[$];
    int                 checks;
    int                 failures;
    bit                 stim_done;

    alu_top #(.WIDTH(c_width)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .opcode (opcode),
        .led    (led),
        .z      (z),
        .c      (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge so the DUT captures the vector on the next
    // rising edge. The monitor then checks it 1 ns after that edge.
    task automatic apply(input string nm, input logic rst, input logic [2:0] op,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] ey, input logic ez, input logic ec);
        @(negedge clk);
        rst_n  = rst;
        opcode = op;
        a      = va;
        b      = vb;
        exp_q.push_back({ey, ez, ec});
        name_q.push_back(nm);
    endtask

    // Monitor
    initial begin
        logic [c_width+1:0] e;
        string              nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if ({led, z, c} !== e) begin
                    failures++;
                    $display("FAIL %s: got led=%b z=%b c=%b, want led=%b z=%b c=%b",
                             nm, led, z, c, e[5:2], e[1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        checks    = 0;
        failures  = 0;
        stim_done = 1'b0;
        rst_n     = 1'b0;
        a         = 4'b0101;
        b         = 4'b0011;
        opcode    = 3'b000;

        // reset held two cycles with a live ADD on the inputs
        apply("rst0",      1'b0, 3'b000, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b0);
        apply("rst1",      1'b0, 3'b000, 4'b0101, 4'b0011, 4'b0000, 1'b0, 1'b0);
        apply("add_rel",   1'b1, 3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b0);
        apply("add_wrap",  1'b1, 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
        apply("sub_nb",    1'b1, 3'b001, 4'b1001, 4'b0010, 4'b0111, 1'b0, 1'b0);
        apply("sub_b",     1'b1, 3'b001, 4'b0010, 4'b1001, 4'b1001, 1'b0, 1'b1);
        apply("sub_wrap",  1'b1, 3'b001, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b1);
        apply("and",       1'b1, 3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0);
        apply("or",        1'b1, 3'b011, 4'b0110, 4'b0011, 4'b0111, 1'b0, 1'b0);
        apply("xor",       1'b1, 3'b100, 4'b1111, 4'b0101, 4'b1010, 1'b0, 1'b0);
        apply("not",       1'b1, 3'b101, 4'b1010, 4'b1111, 4'b0101, 1'b0, 1'b0);
        apply("shl_c0",    1'b1, 3'b110, 4'b0011, 4'b0000, 4'b0110, 1'b0, 1'b0);
        apply("shl_c1",    1'b1, 3'b110, 4'b1001, 4'b0000, 4'b0010, 1'b0, 1'b1);
        apply("shr_c0",    1'b1, 3'b111, 4'b1000, 4'b0000, 4'b0100, 1'b0, 1'b0);
        apply("shr_c1",    1'b1, 3'b111, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
        apply("add_zero",  1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        apply("and_zero",  1'b1, 3'b010, 4'b1010, 4'b0101, 4'b0000, 1'b1, 1'b0);
        // one-cycle reset in the middle of a stream that would otherwise set both flags
        apply("rst_mid",   1'b0, 3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0);
        apply("xor_res",   1'b1, 3'b100, 4'b0011, 4'b0101, 4'b0110, 1'b0, 1'b0);
        apply("or_zero",   1'b1, 3'b011, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        apply("add_8p8",   1'b1, 3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1);
        apply("sub_eq",    1'b1, 3'b001, 4'b0111, 4'b0111, 4'b0000, 1'b1, 1'b0);
        apply("shl_msb",   1'b1, 3'b110, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        apply("shr_ones",  1'b1, 3'b111, 4'b1111, 4'b0000, 4'b0111, 1'b0, 1'b1);
        apply("not_zero",  1'b1, 3'b101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
        apply("add_carry", 1'b1, 3'b000, 4'b1010, 4'b0111, 4'b0001, 1'b0, 1'b1);
        stim_done = 1'b1;

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
